// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: one-deep sample holding buffer feeding a 2*SAMPLE_WIDTH-slot
// frame shifter, advanced by bclk half-period strobes from the upstream clock divider.
module i2s_tx_serializer #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    bclk_tick,
    input  logic                    enable,
    input  logic                    in_valid,
    input  logic [SAMPLE_WIDTH-1:0] in_left,
    input  logic [SAMPLE_WIDTH-1:0] in_right,
    output logic                    in_ready,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    sdata,
    output logic                    underflow
);

    localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
    localparam int SLOT_W     = $clog2(FRAME_BITS);

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_LOAD  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SAMPLE_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_reg;
    logic                    hold_valid_reg;
    logic [FRAME_BITS-1:0]   hold_data_reg;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [SLOT_W-1:0]       slot_reg;
    logic                    bclk_reg;
    logic                    lrclk_reg;
    logic                    sdata_reg;
    logic                    underflow_reg;

    logic [SLOT_W-1:0]       slot_next;
    logic                    accept;
    logic                    load_frame;

    assign in_ready  = ~hold_valid_reg;
    assign accept    = in_valid & ~hold_valid_reg;
    assign slot_next = (slot_reg == SLOT_LAST) ? '0 : slot_reg + SLOT_W'(1);

    // A frame load happens on the falling bclk transition that enters slot 1.
    assign load_frame = (state_reg == RUN) & enable & bclk_tick & bclk_reg
                      & (slot_next == SLOT_LOAD);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
        end else if (accept) begin
            hold_valid_reg <= 1'b1;
            hold_data_reg  <= {in_left, in_right};
        end else if (load_frame) begin
            hold_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            slot_reg      <= '0;
            shift_reg     <= '0;
            bclk_reg      <= 1'b0;
            lrclk_reg     <= 1'b0;
            sdata_reg     <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            underflow_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    slot_reg  <= '0;
                    shift_reg <= '0;
                    bclk_reg  <= 1'b0;
                    lrclk_reg <= 1'b0;
                    sdata_reg <= 1'b0;
                    if (enable) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        // Drop the partial frame; the holding buffer is left untouched.
                        state_reg <= IDLE;
                        slot_reg  <= '0;
                        shift_reg <= '0;
                        bclk_reg  <= 1'b0;
                        lrclk_reg <= 1'b0;
                        sdata_reg <= 1'b0;
                    end else if (bclk_tick) begin
                        bclk_reg <= ~bclk_reg;
                        if (bclk_reg) begin
                            slot_reg  <= slot_next;
                            lrclk_reg <= (slot_next >= SLOT_RIGHT);
                            if (slot_next == SLOT_LOAD) begin
                                if (hold_valid_reg) begin
                                    shift_reg <= hold_data_reg;
                                    sdata_reg <= hold_data_reg[FRAME_BITS-1];
                                end else begin
                                    shift_reg     <= '0;
                                    sdata_reg     <= 1'b0;
                                    underflow_reg <= 1'b1;
                                end
                            end else begin
                                shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                                sdata_reg <= shift_reg[FRAME_BITS-2];
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bclk      = bclk_reg;
    assign lrclk     = lrclk_reg;
    assign sdata     = sdata_reg;
    assign underflow = underflow_reg;

endmodule
